vad_power_tx: RTL and testbench

Transmit side of the voice-activity power link. Accepts complex spectral bins (real/imag) from the FFT stage, squares and sums them into per-bin power words, and delivers them one at a time as 50-bit signed values strobed by `dv` pulses. It then raises `ready` once per frame so the downstream VAD can latch its accumulated frame power and compare it against the threshold. A small FIFO decouples one-bin-per-cycle FFT output from the two-cycle-per-word `dv` pulse protocol.

---
 rtl/vad_power_tx_if.sv | 31 +++
 rtl/vad_power_tx.sv | 194 +++++++++++++++++++
 tb/tb_vad_power_tx.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vad_power_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : vad_power_tx_if
// Description : Bin input handshake plus power-word / frame-strobe output
//               bundle of the voice-activity power transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vad_power_tx_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               in_last;
    logic signed [49:0] data;
    logic               dv;
    logic               ready;
    logic               busy;

    // Producer of bins / consumer of power words
    modport master (
        output in_valid, in_re, in_im, in_last,
        input  in_ready, data, dv, ready, busy
    );

    // The transmitter itself
    modport slave (
        input  in_valid, in_re, in_im, in_last,
        output in_ready, data, dv, ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/vad_power_tx.sv
`default_nettype none
// ============================================================================
// Module      : vad_power_tx
// Description : Squares complex FFT bins into power words, buffers them in a
//               small FIFO and sends them out as dv-strobed words, followed
//               by a ready burst once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vad_power_tx #(
    parameter int FIFO_DEPTH   = 8,
    parameter int READY_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    vad_power_tx_if.slave      bus
);
    localparam int              c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int              c_CNT_W       = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_ACCEPT_LIM = c_CNT_W'(FIFO_DEPTH - 2);
    localparam logic [15:0]     c_GAP_LOAD    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0]     c_RDY_LOAD    = 16'(READY_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HI   = 3'd1;
    localparam logic [2:0] c_ST_LO   = 3'd2;
    localparam logic [2:0] c_ST_GAP  = 3'd3;
    localparam logic [2:0] c_ST_RDY  = 3'd4;

    // ---------------- square pipeline ----------------
    logic signed [31:0] w_re_ext;
    logic signed [31:0] w_im_ext;
    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;
    logic               w_in_ready;
    logic               w_accept;

    logic               r_s1_valid;
    logic               r_s1_last;
    logic [31:0]        r_s1_re2;
    logic [31:0]        r_s1_im2;
    logic               r_s2_valid;
    logic               r_s2_last;
    logic [32:0]        r_s2_pow;

    assign w_re_ext = 32'(bus.in_re);
    assign w_im_ext = 32'(bus.in_im);
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;
    assign w_accept = bus.in_valid && w_in_ready;

    // Two-stage square-and-sum pipeline; stage 2 feeds the FIFO write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_re2   <= '0;
            r_s1_im2   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_pow   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_last  <= bus.in_last;
            r_s1_re2   <= w_re_sq;
            r_s1_im2   <= w_im_sq;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_pow   <= {1'b0, r_s1_re2} + {1'b0, r_s1_im2};
        end
    end

    // ---------------- power-word FIFO ----------------
    logic [33:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [33:0]        w_head;

    logic [2:0]         r_state;
    logic               r_last;

    assign w_push  = r_s2_valid;
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = !w_empty && ((r_state == c_ST_IDLE) ||
                                  ((r_state == c_ST_LO) && !r_last));

    // Two entries stay reserved for the words already inside the pipeline
    assign w_in_ready = !reset && (r_count < c_ACCEPT_LIM);

    // FIFO storage: contents need no reset, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s2_last, r_s2_pow};
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count as is
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- transmit FSM ----------------
    logic [32:0] r_pow;
    logic        r_dv;
    logic        r_ready;
    logic [15:0] r_tmr;

    // Word pacing (HI/LO), then the post-frame gap and ready burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_pow   <= '0;
            r_last  <= 1'b0;
            r_dv    <= 1'b0;
            r_ready <= 1'b0;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_pow   <= w_head[32:0];
                        r_last  <= w_head[33];
                        r_dv    <= 1'b1;
                        r_state <= c_ST_HI;
                    end
                end
                c_ST_HI: begin
                    r_dv    <= 1'b0;
                    r_state <= c_ST_LO;
                end
                c_ST_LO: begin
                    if (r_last) begin
                        r_tmr   <= c_GAP_LOAD;
                        r_state <= c_ST_GAP;
                    end else if (w_pop) begin
                        r_pow   <= w_head[32:0];
                        r_last  <= w_head[33];
                        r_dv    <= 1'b1;
                        r_state <= c_ST_HI;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_GAP: begin
                    if (r_tmr == '0) begin
                        r_tmr   <= c_RDY_LOAD;
                        r_ready <= 1'b1;
                        r_state <= c_ST_RDY;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                c_ST_RDY: begin
                    if (r_tmr == '0) begin
                        r_ready <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                default: begin
                    r_dv    <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.data     = {17'b0, r_pow};
    assign bus.dv       = r_dv;
    assign bus.ready    = r_ready;
    assign bus.busy     = (r_state != c_ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_vad_power_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_vad_power_tx
// Description : Directed self-checking bench for vad_power_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vad_power_tx;
    localparam int FIFO_DEPTH   = 8;
    localparam int READY_CYCLES = 4;
    localparam int GAP_CYCLES   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vad_power_tx_if bus();

    vad_power_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .READY_CYCLES (READY_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stalls = 0;
    int overlap  = 0;
    int overflow = 0;
    int          dv_cyc[$];
    logic [49:0] dv_data[$];
    int          rdy_cyc[$];
    logic [49:0] exp_q[$];

    // Cycle index
    always @(posedge clk) cyc <= cyc + 1;

    // Output logger and protocol watch
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.dv) begin
                dv_cyc.push_back(cyc);
                dv_data.push_back(bus.data);
            end
            if (bus.ready) rdy_cyc.push_back(cyc);
            if (bus.dv && bus.ready) overlap++;
            if (dut.r_s2_valid && (dut.r_count == FIFO_DEPTH)) overflow++;
        end
    end

    // Receiver model: accumulate frame power, decide 2 cycles after ready rise
    logic [63:0] rx_acc, rx_frame;
    logic        rx_rdy_d, rx_s1, rx_result;
    always @(posedge clk) begin
        if (reset) begin
            rx_acc <= '0; rx_frame <= '0; rx_rdy_d <= 1'b0; rx_s1 <= 1'b0; rx_result <= 1'b0;
        end else begin
            rx_rdy_d <= bus.ready;
            if (bus.ready && !rx_rdy_d) begin
                rx_frame <= rx_acc;
                rx_acc   <= '0;
                rx_s1    <= 1'b1;
            end else begin
                if (bus.dv) rx_acc <= rx_acc + 64'(bus.data);
                rx_s1 <= 1'b0;
            end
            if (rx_s1) rx_result <= ((rx_frame >> 16) > 64'd12);
        end
    end

    function automatic logic [49:0] pow_of(input int re, input int im);
        longint r = re;
        longint i = im;
        return 50'(r * r + i * i);
    endfunction

    task automatic clear_logs();
        dv_cyc.delete(); dv_data.delete(); rdy_cyc.delete(); exp_q.delete();
        overlap = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after acceptance
    task automatic send_bin(input int re, input int im, input bit last, output int t);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_re    = 16'(re);
        bus.in_im    = 16'(im);
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
            stalls++;
        end
        if (guard >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required accept", guard);
        end
        t = cyc;
        exp_q.push_back(pow_of(re, im));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.dv !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b expected 0", bus.dv); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.data !== 50'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", bus.data); end
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        clear_logs();
        send_bin(3, -4, 1'b1, t);
        idle(20);
        checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL single_dv_count: got %0d expected 1", dv_cyc.size()); end
        if (dv_cyc.size() >= 1) begin
            checks++; if (dv_data[0] !== 50'd25) begin errors++; $display("FAIL single_data: got %0d expected 25", dv_data[0]); end
            checks++; if (dv_cyc[0] != t + 4) begin errors++; $display("FAIL single_latency: got %0d expected %0d", dv_cyc[0] - t, 4); end
        end
        checks++; if (rdy_cyc.size() != READY_CYCLES) begin errors++; $display("FAIL single_ready_len: got %0d expected %0d", rdy_cyc.size(), READY_CYCLES); end
        if (rdy_cyc.size() >= 1 && dv_cyc.size() >= 1) begin
            checks++; if (rdy_cyc[0] != dv_cyc[0] + 2 + GAP_CYCLES) begin errors++; $display("FAIL single_ready_start: got +%0d expected +%0d", rdy_cyc[0] - dv_cyc[0], 2 + GAP_CYCLES); end
            checks++; if (rdy_cyc[rdy_cyc.size()-1] != rdy_cyc[0] + READY_CYCLES - 1) begin errors++; $display("FAIL single_ready_contig: got last %0d expected %0d", rdy_cyc[rdy_cyc.size()-1], rdy_cyc[0] + READY_CYCLES - 1); end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_extremes();
        int t;
        logic [49:0] w;
        logic [16:0] hi;
        clear_logs();
        send_bin(-32768, -32768, 1'b1, t);
        idle(15);
        send_bin(0, 0, 1'b1, t);
        idle(15);
        checks++; if (dv_cyc.size() != 2) begin errors++; $display("FAIL ext_dv_count: got %0d expected 2", dv_cyc.size()); end
        if (dv_cyc.size() >= 2) begin
            w  = dv_data[0];
            hi = w[49:33];
            checks++; if (w !== 50'h0_0000_8000_0000) begin errors++; $display("FAIL ext_max_data: got %0h expected 80000000", w); end
            checks++; if (hi !== 17'd0) begin errors++; $display("FAIL ext_upper_bits: got %0h expected 0", hi); end
            checks++; if (dv_data[1] !== 50'd0) begin errors++; $display("FAIL ext_zero_data: got %0d expected 0", dv_data[1]); end
        end
        checks++; if (rdy_cyc.size() != 2 * READY_CYCLES) begin errors++; $display("FAIL ext_ready_cycles: got %0d expected %0d", rdy_cyc.size(), 2 * READY_CYCLES); end
    endtask

    task automatic test_back_to_back();
        int t;
        int bad_gap = 0;
        int bad_data = 0;
        clear_logs();
        stalls = 0;
        overflow = 0;
        for (int i = 0; i < 256; i++) send_bin(i * 97 - 12000, 15000 - i * 113, i == 255, t);
        idle(40);
        checks++; if (dv_cyc.size() != 256) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 256", dv_cyc.size()); end
        for (int i = 0; i < dv_cyc.size() && i < 256; i++) begin
            if (dv_data[i] !== exp_q[i]) begin
                bad_data++;
                if (bad_data <= 4) $display("FAIL b2b_word_%0d: got %0d expected %0d", i, dv_data[i], exp_q[i]);
            end
            if (i > 0 && dv_cyc[i] != dv_cyc[i-1] + 2) bad_gap++;
        end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_data: got %0d wrong words expected 0", bad_data); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (stalls == 0) begin errors++; $display("FAIL b2b_throttle: got %0d stall cycles expected >0", stalls); end
        checks++; if (overflow != 0) begin errors++; $display("FAIL b2b_overflow: got %0d full writes expected 0", overflow); end
        checks++; if (rdy_cyc.size() != READY_CYCLES) begin errors++; $display("FAIL b2b_ready_len: got %0d expected %0d", rdy_cyc.size(), READY_CYCLES); end
        if (rdy_cyc.size() >= 1 && dv_cyc.size() >= 1) begin
            checks++; if (rdy_cyc[0] != dv_cyc[dv_cyc.size()-1] + 2 + GAP_CYCLES) begin errors++; $display("FAIL b2b_ready_start: got %0d expected %0d", rdy_cyc[0], dv_cyc[dv_cyc.size()-1] + 2 + GAP_CYCLES); end
        end
    endtask

    task automatic test_two_frames();
        int t;
        int re_v[8] = '{10, -30, 50, 70, 1, 2, -3, 4};
        int im_v[8] = '{20, 40, -60, 80, 1, -2, 3, 4};
        int bad_data = 0;
        int rises = 0;
        int gap_viol = 0;
        int last_dv;
        clear_logs();
        overflow = 0;
        for (int i = 0; i < 8; i++) send_bin(re_v[i], im_v[i], (i == 3) || (i == 7), t);
        idle(40);
        checks++; if (dv_cyc.size() != 8) begin errors++; $display("FAIL two_dv_count: got %0d expected 8", dv_cyc.size()); end
        for (int i = 0; i < dv_cyc.size() && i < 8; i++) begin
            if (dv_data[i] !== exp_q[i]) begin
                bad_data++;
                $display("FAIL two_word_%0d: got %0d expected %0d", i, dv_data[i], exp_q[i]);
            end
        end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL two_data: got %0d wrong words expected 0", bad_data); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL two_overlap: got %0d dv&ready cycles expected 0", overlap); end
        for (int i = 0; i < rdy_cyc.size(); i++) begin
            if (i == 0 || rdy_cyc[i] != rdy_cyc[i-1] + 1) begin
                rises++;
                last_dv = -1000;
                for (int j = 0; j < dv_cyc.size(); j++) if (dv_cyc[j] < rdy_cyc[i]) last_dv = dv_cyc[j];
                if (rdy_cyc[i] - last_dv - 1 < GAP_CYCLES) gap_viol++;
            end
        end
        checks++; if (rises != 2) begin errors++; $display("FAIL two_ready_bursts: got %0d expected 2", rises); end
        checks++; if (gap_viol != 0) begin errors++; $display("FAIL two_gap: got %0d short gaps expected 0", gap_viol); end
        checks++; if (rdy_cyc.size() != 2 * READY_CYCLES) begin errors++; $display("FAIL two_ready_cycles: got %0d expected %0d", rdy_cyc.size(), 2 * READY_CYCLES); end
        if (dv_cyc.size() >= 5) begin
            checks++; if (dv_cyc[4] != dv_cyc[3] + 3 + GAP_CYCLES + READY_CYCLES) begin errors++; $display("FAIL two_resume: got +%0d expected +%0d", dv_cyc[4] - dv_cyc[3], 3 + GAP_CYCLES + READY_CYCLES); end
        end
        checks++; if (overflow != 0) begin errors++; $display("FAIL two_overflow: got %0d expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int t;
        int k = 0;
        int guard = 0;
        clear_logs();
        send_bin(5, 5, 1'b0, t);
        send_bin(6, 6, 1'b0, t);
        send_bin(7, 7, 1'b0, t);
        send_bin(8, 8, 1'b1, t);
        while (guard < 50) begin
            if (bus.dv) k++;
            if (k == 2) break;
            @(negedge clk);
            guard++;
        end
        checks++; if (k != 2) begin errors++; $display("FAIL mid_wait_word2: got %0d dv pulses expected 2", k); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.dv !== 1'b0) begin errors++; $display("FAIL mid_dv: got %b expected 0", bus.dv); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.data !== 50'd0) begin errors++; $display("FAIL mid_data: got %0d expected 0", bus.data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        clear_logs();
        send_bin(3, -4, 1'b1, t);
        idle(20);
        checks++; if (dv_cyc.size() != 1) begin errors++; $display("FAIL mid_after_dv_count: got %0d expected 1", dv_cyc.size()); end
        if (dv_cyc.size() >= 1) begin
            checks++; if (dv_data[0] !== 50'd25) begin errors++; $display("FAIL mid_after_data: got %0d expected 25", dv_data[0]); end
            checks++; if (dv_cyc[0] != t + 4) begin errors++; $display("FAIL mid_after_latency: got %0d expected 4", dv_cyc[0] - t); end
        end
        checks++; if (rdy_cyc.size() != READY_CYCLES) begin errors++; $display("FAIL mid_after_ready: got %0d expected %0d", rdy_cyc.size(), READY_CYCLES); end
    endtask

    task automatic test_loopback();
        int t;
        // 1000^2*2 + 500^2*2 = 2500000 -> >>16 = 38 > 12
        clear_logs();
        send_bin(1000, 1000, 1'b0, t);
        send_bin(500, -500, 1'b1, t);
        idle(20);
        checks++; if (rx_result !== 1'b1) begin errors++; $display("FAIL loop_high: got %b expected 1", rx_result); end
        // 100^2*2 + 200^2 + 50^2 = 62500 -> >>16 = 0
        clear_logs();
        send_bin(100, 100, 1'b0, t);
        send_bin(-200, 50, 1'b1, t);
        idle(20);
        checks++; if (rx_result !== 1'b0) begin errors++; $display("FAIL loop_low: got %b expected 0", rx_result); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_extremes();
        test_back_to_back();
        test_two_frames();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
